// File: rtl/pulse_sync_multi.sv
// rtl/pulse_sync_multi.sv - multi-channel toggle-to-event synchroniser with per-channel pending counters
//
// Purpose:
//   Each channel receives events from an unrelated source domain encoded as
//   level toggles on tgl_in. The toggle is resynchronised into clk, edge
//   detected, and added to a per-channel pending counter. Pending events are
//   handed to the consumer one at a time over a valid/ready handshake, so
//   bursts are never lost while the consumer stalls (up to 2^CNT_W-1 pending).
//
// Ports:
//   clk        destination clock
//   rst        synchronous active-high reset (counters and overflow flags)
//   tgl_in     per-channel asynchronous toggle, every level change is one event
//   evt_valid  channel has at least one pending event
//   evt_ready  consumer takes one event from the channel this cycle
//   evt_cnt    pending count, channel i at [i*CNT_W +: CNT_W]
//   ovf        sticky per-channel overflow (event arrived while counter full)
//   ovf_clr    clears the channel's overflow flag (a same-cycle overflow wins)
//
// Optional feature macro: PULSE_SYNC_MULTI_FILT_EN
//   When defined, a synchronised toggle must be stable for two consecutive
//   cycles before it is accepted, rejecting single-cycle glitches at the cost
//   of one extra cycle of latency.

module pulse_sync_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       tgl_in,
    output logic [CH-1:0]       evt_valid,
    input  logic [CH-1:0]       evt_ready,
    output logic [CH*CNT_W-1:0] evt_cnt,
    output logic [CH-1:0]       ovf,
    input  logic [CH-1:0]       ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Synchroniser chain, index 0 is the first capture flop. Deliberately
    // not reset: it must keep tracking tgl_in through reset so that a static
    // level at reset exit does not look like a toggle.
    logic [CH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [CH-1:0]                  sync_last;
    logic [CH-1:0]                  hist_q;
    logic [CH-1:0]                  tgl_det;

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], tgl_in[i]};
        end
    end

    always_comb begin
        sync_last = '0;
        for (int i = 0; i < CH; i++) begin
            sync_last[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

`ifdef PULSE_SYNC_MULTI_FILT_EN
    // A candidate change (sync_last != hist) must persist into a second
    // cycle before acceptance. Since the signal is one bit, "differs from
    // hist on two consecutive cycles with hist unchanged" implies the same
    // new value both cycles.
    logic [CH-1:0] cand;
    logic [CH-1:0] accept;
    logic [CH-1:0] pend_q;

    assign cand   = sync_last ^ hist_q;
    assign accept = cand & pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Track the input during reset so toggles landing now are dropped.
            hist_q <= sync_last;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (accept[i]) begin
                    hist_q[i] <= sync_last[i];
                end
            end
            pend_q <= cand & ~accept;
        end
    end

    assign tgl_det = accept & {CH{~rst}};
`else
    // History follows the synchroniser every cycle, including during reset;
    // only the detect result is masked while rst is high.
    always_ff @(posedge clk) begin
        hist_q <= sync_last;
    end

    assign tgl_det = (sync_last ^ hist_q) & {CH{~rst}};
`endif

    // Pending counters and sticky overflow.
    logic [CH-1:0][CNT_W-1:0] cnt_q;
    logic [CH-1:0][CNT_W-1:0] cnt_d;
    logic [CH-1:0]            ovf_q;
    logic [CH-1:0]            ovf_d;
    logic [CH-1:0]            valid;

    always_comb begin
        valid = '0;
        for (int i = 0; i < CH; i++) begin
            valid[i] = |cnt_q[i];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int i = 0; i < CH; i++) begin
            logic inc;
            logic dec;
            logic ovf_set;
            inc     = tgl_det[i];
            dec     = valid[i] & evt_ready[i];
            ovf_set = 1'b0;
            if (inc && !dec) begin
                if (&cnt_q[i]) begin
                    // Counter full: the event is dropped and flagged.
                    ovf_set = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
            // Set has priority over clear so a same-cycle overflow is kept.
            ovf_d[i] = ovf_set | (ovf_q[i] & ~ovf_clr[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign evt_valid = valid;
    assign evt_cnt   = cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_sync_multi.sv
// tb/tb_pulse_sync_multi.sv - scoreboard bench for pulse_sync_multi

module tb_pulse_sync_multi;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int CW   = 4;
    localparam int MAXP = (1 << CW) - 1;
`ifdef PULSE_SYNC_MULTI_FILT_EN
    localparam int LAT   = SYNC + 2;
    localparam int SPACE = 3;
`else
    localparam int LAT   = SYNC + 1;
    localparam int SPACE = 2;
`endif

    logic             clk;
    logic             rst;
    logic [CH-1:0]    tgl;
    logic [CH-1:0]    evt_valid;
    logic [CH-1:0]    evt_ready;
    logic [CH*CW-1:0] evt_cnt;
    logic [CH-1:0]    ovf;
    logic [CH-1:0]    ovf_clr;

    pulse_sync_multi #(.CH(CH), .SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgl_in    (tgl),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_cnt   (evt_cnt),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int seq      = 0;
    int evq [CH][$];
    bit exp_ovf [CH];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] cnt_of(input int c);
        return evt_cnt[c*CW +: CW];
    endfunction

    // Reference rule: an issued event is either queued, or lost with an
    // overflow flag when the channel already holds the maximum pending count.
    task automatic flip(input int c);
        tgl[c] = ~tgl[c];
        if (evq[c].size() < MAXP) evq[c].push_back(seq++);
        else exp_ovf[c] = 1'b1;
    endtask

    task automatic clear_model();
        for (int c = 0; c < CH; c++) begin
            evq[c].delete();
            exp_ovf[c] = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 1'b0;
        evt_ready = '1;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = (evt_valid == '0);
            for (int c = 0; c < CH; c++) if (evq[c].size() != 0) done = 1'b0;
        end
        check({nm, "_drain_done"}, done, 1);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("%s_cnt_ch%0d", nm, c), cnt_of(c), evq[c].size());
        end
        evt_ready = '0;
    endtask

    // Monitor: every handshake must consume one expected event.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                if (evt_valid[c] && evt_ready[c]) begin
                    n_checks++;
                    if (evq[c].size() == 0) begin
                        n_fail++;
                        $display("FAIL handshake_ch%0d: got event, expected 0 pending", c);
                    end else begin
                        void'(evq[c].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int last [CH];
        int nt   [CH];
        rst = 1'b1; tgl = 4'b1010; evt_ready = '0; ovf_clr = '0;
        clear_model();

        // Reset state and static level at reset exit
        repeat (5) tick();
        check("rst_valid", evt_valid, 0);
        check("rst_cnt", evt_cnt, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        repeat (20) begin
            tick();
            check("static_valid", evt_valid, 0);
            check("static_cnt", evt_cnt, 0);
        end

        // Single toggle latency on ch0 with ready held high
        evt_ready = 4'b0001;
        flip(0);
        for (int k = 1; k < LAT; k++) begin
            tick();
            check("lat_early_valid0", evt_valid[0], 0);
        end
        tick();
        check("lat_valid0", evt_valid[0], 1);
        check("lat_cnt0", cnt_of(0), 1);
        tick();
        check("lat_after_valid0", evt_valid[0], 0);
        check("lat_after_cnt0", cnt_of(0), 0);
        evt_ready = '0;
        repeat (4) tick();

        // Five queued events on ch2, then drained one per cycle
        for (int k = 0; k < 5; k++) begin
            flip(2);
            repeat (SPACE) tick();
        end
        repeat (LAT) tick();
        check("burst_cnt2", cnt_of(2), 5);
        check("burst_model2", cnt_of(2), evq[2].size());
        evt_ready[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("burst_drain_%0d", k), cnt_of(2), 5 - k);
        end
        check("burst_valid2_low", evt_valid[2], 0);
        evt_ready = '0;

        // Saturation and overflow on ch1
        for (int k = 0; k < 16; k++) begin
            flip(1);
            repeat (SPACE) tick();
        end
        repeat (LAT) tick();
        check("sat_cnt1", cnt_of(1), MAXP);
        check("sat_ovf1", ovf[1], exp_ovf[1]);
        check("sat_ovf_other", ovf & 4'b1101, 0);
        ovf_clr[1] = 1'b1;
        exp_ovf[1] = 1'b0;
        tick();
        ovf_clr = '0;
        check("ovfclr_ovf1", ovf[1], 0);
        check("ovfclr_cnt1", cnt_of(1), MAXP);
        drain("sat");

        // Simultaneous inc and dec on ch3 at cnt=3 and at cnt=max
        for (int k = 0; k < 3; k++) begin
            flip(3);
            repeat (SPACE) tick();
        end
        repeat (LAT) tick();
        check("incdec_pre3", cnt_of(3), 3);
        tgl[3] = ~tgl[3];
        evq[3].push_back(seq++);
        repeat (LAT - 1) tick();
        evt_ready[3] = 1'b1;
        tick();
        evt_ready[3] = 1'b0;
        check("incdec_cnt3", cnt_of(3), 3);
        tick();
        check("incdec_cnt3_hold", cnt_of(3), 3);
        for (int k = 0; k < MAXP - 3; k++) begin
            flip(3);
            repeat (SPACE) tick();
        end
        repeat (LAT) tick();
        check("incdec_premax", cnt_of(3), MAXP);
        tgl[3] = ~tgl[3];
        evq[3].push_back(seq++);
        repeat (LAT - 1) tick();
        evt_ready[3] = 1'b1;
        tick();
        evt_ready[3] = 1'b0;
        check("incdec_max_cnt", cnt_of(3), MAXP);
        check("incdec_max_ovf", ovf[3], 0);
        tick();
        check("incdec_max_ovf_hold", ovf[3], 0);
        drain("incdec");

        // Reset mid-operation with an in-flight toggle on ch0
        for (int k = 0; k < 7; k++) begin
            flip(0);
            repeat (SPACE) tick();
        end
        repeat (LAT) tick();
        check("midrst_pre_cnt0", cnt_of(0), 7);
        flip(0);
        tick();
        rst = 1'b1;
        clear_model();
        repeat (5) tick();
        check("midrst_cnt", evt_cnt, 0);
        check("midrst_ovf", ovf, 0);
        rst = 1'b0;
        repeat (10) tick();
        check("midrst_after_cnt", evt_cnt, 0);
        check("midrst_after_valid", evt_valid, 0);
        flip(0);
        repeat (LAT + 2) tick();
        check("midrst_next_cnt0", cnt_of(0), 1);
        drain("midrst");

        // Randomized traffic on all channels, at most 10 events per channel
        for (int c = 0; c < CH; c++) begin
            last[c] = -100;
            nt[c]   = 0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick();
            evt_ready = CH'($urandom);
            for (int c = 0; c < CH; c++) begin
                if (cyc - last[c] >= SPACE && nt[c] < 10 && $urandom_range(3) == 0) begin
                    flip(c);
                    last[c] = cyc;
                    nt[c]++;
                end
            end
        end
        drain("rand");
        check("rand_ovf", ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
